// File: rtl/return_stack_unit.sv
// ---------------------------------------------------------------------------
// return_stack_unit
//
// Hardware return-address stack placed after the instruction decoder.
// A CALL-type opcode pushes pc+1 into an internal LIFO; a RET-type opcode
// pops the top entry into ret_addr. The stack pointer, occupancy and sticky
// overflow/underflow status are published for the control unit.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-high reset
//   enable     in   request valid from decoder
//   opcode     in   decoded opcode (OP_PUSH / OP_POP act, others ignored)
//   pc         in   current program counter
//   clear_err  in   clears sticky flags; leaves ERROR state
//   ready      out  request can be accepted this cycle (IDLE only)
//   ret_addr   out  last popped return address (registered)
//   ret_valid  out  one-cycle pulse when ret_addr was just updated
//   sp_out     out  STACK_TOP - depth
//   depth      out  number of valid entries (0..DEPTH)
//   full       out  depth == DEPTH
//   empty      out  depth == 0
//   overflow   out  sticky: push attempted while full
//   underflow  out  sticky: pop attempted while empty
// ---------------------------------------------------------------------------
module return_stack_unit #(
  parameter int              DEPTH     = 16,
  parameter int              AW        = 4,
  parameter int              DATA_W    = 16,
  parameter logic [5:0]      OP_PUSH   = 6'b000101,
  parameter logic [5:0]      OP_POP    = 6'b000100,
  parameter logic [DATA_W-1:0] STACK_TOP = 16'hFFFF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [5:0]        opcode,
  input  logic [DATA_W-1:0] pc,
  input  logic              clear_err,
  output logic              ready,
  output logic [DATA_W-1:0] ret_addr,
  output logic              ret_valid,
  output logic [DATA_W-1:0] sp_out,
  output logic [AW:0]       depth,
  output logic              full,
  output logic              empty,
  output logic              overflow,
  output logic              underflow
);

  typedef enum logic [1:0] {IDLE, PUSH, POP, ERROR} state_t;

  localparam logic [AW:0]       DEPTH_ONE = (AW+1)'(1);
  localparam logic [AW:0]       DEPTH_MAX = (AW+1)'(DEPTH);
  localparam logic [DATA_W-1:0] PC_ONE    = DATA_W'(1);

  state_t            state_reg, state_next;
  logic [AW:0]       depth_reg, depth_next;
  logic [DATA_W-1:0] pc_reg;
  logic [DATA_W-1:0] ret_addr_reg;
  logic              ret_valid_reg;
  logic              overflow_reg, underflow_reg;
  logic              set_ovf, set_unf;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              is_push, is_pop, accept;
  logic [AW-1:0]     wr_idx, rd_idx;

  assign ready   = (state_reg == IDLE);
  assign is_push = (opcode == OP_PUSH);
  assign is_pop  = (opcode == OP_POP);
  assign accept  = ready && enable && (is_push || is_pop);

  assign full    = (depth_reg == DEPTH_MAX);
  assign empty   = (depth_reg == '0);
  assign depth   = depth_reg;
  assign sp_out  = STACK_TOP - DATA_W'(depth_reg);

  // Push writes at the current depth; pop reads the entry just below it.
  // Each index is only used in the state where it is guaranteed in range.
  assign wr_idx  = depth_reg[AW-1:0];
  assign rd_idx  = AW'(depth_reg - DEPTH_ONE);

  assign ret_addr  = ret_addr_reg;
  assign ret_valid = ret_valid_reg;
  assign overflow  = overflow_reg;
  assign underflow = underflow_reg;

  always_comb begin
    state_next = state_reg;
    depth_next = depth_reg;
    set_ovf    = 1'b0;
    set_unf    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          if (is_push) begin
            if (full) begin
              state_next = ERROR;
              set_ovf    = 1'b1;
            end else begin
              state_next = PUSH;
            end
          end else begin
            if (empty) begin
              state_next = ERROR;
              set_unf    = 1'b1;
            end else begin
              state_next = POP;
            end
          end
        end
      end
      PUSH: begin
        depth_next = depth_reg + DEPTH_ONE;
        state_next = IDLE;
      end
      POP: begin
        depth_next = depth_reg - DEPTH_ONE;
        state_next = IDLE;
      end
      ERROR: begin
        if (clear_err) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      depth_reg     <= '0;
      pc_reg        <= '0;
      ret_addr_reg  <= '0;
      ret_valid_reg <= 1'b0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      depth_reg     <= depth_next;
      ret_valid_reg <= (state_reg == POP);
      if (accept) pc_reg <= pc;
      if (state_reg == POP) ret_addr_reg <= mem[rd_idx];
      // A new error in the same cycle as clear_err must not be lost.
      if (set_ovf)        overflow_reg <= 1'b1;
      else if (clear_err) overflow_reg <= 1'b0;
      if (set_unf)        underflow_reg <= 1'b1;
      else if (clear_err) underflow_reg <= 1'b0;
    end
  end

  // Storage is not reset. Reset forces state_reg to IDLE asynchronously,
  // so an interrupted PUSH never reaches this write.
  always_ff @(posedge clk) begin
    if (state_reg == PUSH) mem[wr_idx] <= pc_reg + PC_ONE;
  end

endmodule
